// File: rtl/swt_debounce.sv
// swt_debounce
// ------------
// Synchroniser and debouncer for the four Basys3 slide switches.
// Each switch bit has the same chain: a 2-flop synchroniser, a stability
// counter and a debounced output flop. A new level is accepted only after the
// synchronised input has differed from the output for STABLE_CYCLES
// consecutive cycles. Any cycle in which it matches the output again restarts
// that count from zero.
//
// Build option:
//   SWT_DEBOUNCE_CHG_EN  defined   -> registered one-cycle change pulses on chg
//                        undefined -> chg tied to 4'b0000 (port kept)
//
// Parameter legal range: 1 <= STABLE_CYCLES <= 2**CNT_W.
// Reset is synchronous and active-high.

module swt_debounce #(
    parameter int STABLE_CYCLES = 1000000,
    parameter int CNT_W         = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw_raw,
    output logic [3:0] swt,
    output logic [3:0] chg,
    output logic       stable
);

    // Terminal count. Reaching it while the mismatch persists accepts the
    // new level. The counter is cleared at that same edge, so it never wraps.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    logic [3:0]       s1_q;
    logic [3:0]       s2_q;
    logic [3:0]       swt_q;
    logic [3:0]       swt_d;
    logic [3:0]       acceptHit;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];

    // Two-stage synchroniser bringing the asynchronous pins into the clk domain
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 4'b0000;
            s2_q <= 4'b0000;
        end else begin
            s1_q <= sw_raw;
            s2_q <= s1_q;
        end
    end

    // Per-bit qualification: clear on match, accept at terminal count, else count up
    always_comb begin
        acceptHit = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == swt_q[i]) begin
                cnt_d[i] = CNT_ZERO;
            end else if (cnt_q[i] == CNT_LAST) begin
                cnt_d[i]     = CNT_ZERO;
                acceptHit[i] = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
        // An accepted bit can only move towards s2, and s2 differs from swt
        // whenever it is accepted, so a toggle is exact.
        swt_d = swt_q ^ acceptHit;
    end

    // Stability counters and debounced outputs. Reset discards any partial count.
    always_ff @(posedge clk) begin
        if (rst) begin
            swt_q <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= CNT_ZERO;
            end
        end else begin
            swt_q <= swt_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef SWT_DEBOUNCE_CHG_EN
    logic [3:0] chg_q;

    // Change pulses, high for the single cycle after a bit is accepted; reset itself never pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            chg_q <= 4'b0000;
        end else begin
            chg_q <= acceptHit;
        end
    end

    assign chg = chg_q;
`else
    assign chg = 4'b0000;
`endif

    assign swt = swt_q;

    // Settled when every synchronised level already matches its debounced output
    assign stable = &(~(s2_q ^ swt_q));

endmodule

// File: tb/tb_swt_debounce.sv
// tb_swt_debounce
// ---------------
// Bench for swt_debounce with STABLE_CYCLES = 4 and CNT_W = 3.
// Inputs change just after a falling edge, and outputs are sampled on the
// next falling edge.
//
// The reference model records the raw pins and reset at every rising edge.
// From that history it applies the acceptance rule directly: a bit flips at
// an edge when the synchronised level, which is the pin value two edges
// earlier, has differed from the current output at each of the last
// STABLE_CYCLES edges, with no reset among them.

module tb_swt_debounce;

    localparam int S     = 4;
    localparam int DEPTH = 4096;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sw_raw;
    logic [3:0] swt;
    logic [3:0] chg;
    logic       stable;

    int checks = 0;
    int errors = 0;

    swt_debounce #(
        .STABLE_CYCLES(S),
        .CNT_W        (3)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .sw_raw(sw_raw),
        .swt   (swt),
        .chg   (chg),
        .stable(stable)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit [3:0] rawAt [DEPTH];
    bit       rstAt [DEPTH];
    int       edgeN   = 0;
    logic [3:0] mOut    = 4'b0000;
    logic [3:0] mChg    = 4'b0000;
    logic       mStable = 1'b1;
    logic [3:0] expChgM;

    // Synchronised level seen just before edge e
    function automatic bit [3:0] syncOf(int e);
        if (e < 2) return 4'b0000;
        if (rstAt[e-1] || rstAt[e-2]) return 4'b0000;
        return rawAt[e-2];
    endfunction

    // Behavioural model updated at every rising edge
    always @(posedge clk) begin
        if (edgeN < DEPTH - 1) begin
            rawAt[edgeN] = sw_raw;
            rstAt[edgeN] = rst;
            mChg = 4'b0000;
            if (rst) begin
                mOut = 4'b0000;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    bit ok;
                    bit [3:0] sv;
                    ok = (edgeN >= S + 1);
                    for (int j = 0; j < S; j++) begin
                        if (ok) begin
                            sv = syncOf(edgeN - j);
                            if (rstAt[edgeN - j] || (sv[i] == mOut[i])) ok = 1'b0;
                        end
                    end
                    if (ok) begin
                        mOut[i] = ~mOut[i];
                        mChg[i] = 1'b1;
                    end
                end
            end
            edgeN++;
            mStable = (syncOf(edgeN) == mOut);
        end
    end

`ifdef SWT_DEBOUNCE_CHG_EN
    assign expChgM = mChg;
    localparam bit CHG_ON = 1'b1;
`else
    assign expChgM = 4'b0000;
    localparam bit CHG_ON = 1'b0;
`endif

    // Drive inputs; callers are always positioned just after a falling edge
    task automatic applyStimulus(input logic [3:0] v, input logic r);
        sw_raw = v;
        rst    = r;
    endtask

    // Return to an idle, settled state with all outputs low
    task automatic settle();
        applyStimulus(4'b0000, 1'b0);
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        applyStimulus(4'b1111, 1'b1);
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            checks++;
            if (swt !== 4'b0000) begin
                errors++; $display("[TB] FAIL reset_swt cycle %0d: got %b expected 0000", k, swt);
            end
            checks++;
            if (chg !== 4'b0000) begin
                errors++; $display("[TB] FAIL reset_chg cycle %0d: got %b expected 0000", k, chg);
            end
            checks++;
            if (stable !== 1'b1) begin
                errors++; $display("[TB] FAIL reset_stable cycle %0d: got %b expected 1", k, stable);
            end
        end
        applyStimulus(4'b1111, 1'b0);
        @(negedge clk);
        checks++;
        if ({swt, chg, stable} !== 9'b0000_0000_1) begin
            errors++; $display("[TB] FAIL post_reset: got swt=%b chg=%b stable=%b expected 0000 0000 1", swt, chg, stable);
        end
        settle();
    endtask

    task automatic test_clean_step();
        logic [3:0] eSwt, eChg;
        logic       eSt;
        applyStimulus(4'b0101, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            eSwt = (k >= 6) ? 4'b0101 : 4'b0000;
            eChg = (CHG_ON && k == 6) ? 4'b0101 : 4'b0000;
            eSt  = !(k >= 2 && k < 6);
            checks++;
            if (swt !== eSwt) begin
                errors++; $display("[TB] FAIL clean_swt edge %0d: got %b expected %b", k, swt, eSwt);
            end
            checks++;
            if (chg !== eChg) begin
                errors++; $display("[TB] FAIL clean_chg edge %0d: got %b expected %b", k, chg, eChg);
            end
            checks++;
            if (stable !== eSt) begin
                errors++; $display("[TB] FAIL clean_stable edge %0d: got %b expected %b", k, stable, eSt);
            end
        end
        settle();
    endtask

    task automatic test_bounce();
        logic [3:0] eSwt, eChg;
        // pin high for 3 cycles, low for 1, then high and held
        for (int k = 1; k <= 14; k++) begin
            applyStimulus((k == 4) ? 4'b0000 : 4'b0001, 1'b0);
            @(negedge clk);
            eSwt = (k >= 10) ? 4'b0001 : 4'b0000;
            eChg = (CHG_ON && k == 10) ? 4'b0001 : 4'b0000;
            checks++;
            if (swt !== eSwt) begin
                errors++; $display("[TB] FAIL bounce_swt edge %0d: got %b expected %b", k, swt, eSwt);
            end
            checks++;
            if (chg !== eChg) begin
                errors++; $display("[TB] FAIL bounce_chg edge %0d: got %b expected %b", k, chg, eChg);
            end
        end
        settle();
    endtask

    task automatic test_glitch();
        logic eSt;
        for (int k = 1; k <= 10; k++) begin
            applyStimulus((k <= 3) ? 4'b1000 : 4'b0000, 1'b0);
            @(negedge clk);
            eSt = !(k >= 2 && k <= 4);
            checks++;
            if ({swt, chg} !== 8'h00) begin
                errors++; $display("[TB] FAIL glitch_out edge %0d: got swt=%b chg=%b expected 0000 0000", k, swt, chg);
            end
            checks++;
            if (stable !== eSt) begin
                errors++; $display("[TB] FAIL glitch_stable edge %0d: got %b expected %b", k, stable, eSt);
            end
        end
        settle();
    endtask

    task automatic test_reset_mid();
        logic [3:0] eSwt, eChg;
        // edges 1-5 run normally (edges 3-5 count), edges 6-7 are in reset
        for (int k = 1; k <= 15; k++) begin
            applyStimulus(4'b1000, (k == 6 || k == 7));
            @(negedge clk);
            eSwt = (k >= 13) ? 4'b1000 : 4'b0000;
            eChg = (CHG_ON && k == 13) ? 4'b1000 : 4'b0000;
            checks++;
            if (swt !== eSwt) begin
                errors++; $display("[TB] FAIL rstmid_swt edge %0d: got %b expected %b", k, swt, eSwt);
            end
            checks++;
            if (chg !== eChg) begin
                errors++; $display("[TB] FAIL rstmid_chg edge %0d: got %b expected %b", k, chg, eChg);
            end
        end
        settle();
    endtask

    task automatic test_random();
        logic [3:0] v;
        v = 4'b0000;
        for (int k = 0; k < 600; k++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 7) == 0) v[b] = ~v[b];
            end
            applyStimulus(v, ($urandom_range(0, 79) == 0));
            @(negedge clk);
            checks++;
            if (swt !== mOut) begin
                errors++; $display("[TB] FAIL random_swt step %0d: got %b expected %b", k, swt, mOut);
            end
            checks++;
            if (chg !== expChgM) begin
                errors++; $display("[TB] FAIL random_chg step %0d: got %b expected %b", k, chg, expChgM);
            end
            checks++;
            if (stable !== mStable) begin
                errors++; $display("[TB] FAIL random_stable step %0d: got %b expected %b", k, stable, mStable);
            end
        end
        settle();
    endtask

    initial begin
        applyStimulus(4'b0000, 1'b1);
        test_reset();
        test_clean_step();
        test_bounce();
        test_glitch();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
